// File: rtl/branch_pred_unit.sv
// ---------------------------------------------------------------------------
// branch_pred_unit
//
// Resolves one conditional branch per cycle and maintains a bimodal branch
// history table (BHT) of 2-bit saturating counters for the fetch stage.
//
// Fetch side
//   lookup_pc_i     : fetch PC; low IDX_W bits index the BHT
//   pred_taken_o    : combinational prediction (MSB of the indexed counter)
//
// Resolve side (registered, one-cycle latency)
//   valid_i/flush_i : request is accepted when valid_i=1 and flush_i=0
//   pc_i, src_i     : branch PC and offset (or absolute target if abs_i=1)
//   cc_i, flags_i   : condition select/invert and processor flags
//   pred_taken_i    : prediction fetch used for this branch
//   valid_o         : one-cycle pulse per accepted request
//   branch_en_o     : actual taken outcome
//   dest_addr_o     : branch target
//   mispredict_o    : outcome differed from pred_taken_i
//   redirect_addr_o : correct next PC (target or fall-through)
//   mispred_cnt_o   : saturating count of mispredicts
// ---------------------------------------------------------------------------
module branch_pred_unit #(
  parameter int XLEN      = 32,
  parameter int BHT_DEPTH = 16,
  parameter int CNT_W     = 16
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [XLEN-1:0]  lookup_pc_i,
  output logic             pred_taken_o,
  input  logic             valid_i,
  input  logic [XLEN-1:0]  pc_i,
  input  logic [3:0]       cc_i,
  input  logic [5:0]       flags_i,
  input  logic [XLEN-1:0]  src_i,
  input  logic             abs_i,
  input  logic             pred_taken_i,
  input  logic             flush_i,
  output logic             valid_o,
  output logic             branch_en_o,
  output logic [XLEN-1:0]  dest_addr_o,
  output logic             mispredict_o,
  output logic [XLEN-1:0]  redirect_addr_o,
  output logic [CNT_W-1:0] mispred_cnt_o
);

  localparam int IDX_W = $clog2(BHT_DEPTH);

  typedef enum logic [2:0] {
    CC_ALWAYS = 3'd0,
    CC_Z      = 3'd1,
    CC_P      = 3'd2,
    CC_N      = 3'd3,
    CC_C      = 3'd4,
    CC_V      = 3'd5,
    CC_NEVER0 = 3'd6,
    CC_NEVER1 = 3'd7
  } cc_sel_e;

  // Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
  localparam logic [1:0] BHT_RESET = 2'b01;

  logic [1:0]       bht [BHT_DEPTH];
  logic [IDX_W-1:0] lookup_idx;
  logic [IDX_W-1:0] upd_idx;
  cc_sel_e          cc_sel;
  logic             raw_cond;
  logic             taken;
  logic             accept;
  logic             mispredict;
  logic [XLEN-1:0]  target;
  logic [XLEN-1:0]  fall_through;
  logic [1:0]       bht_next;

  // Address bits above the index and the reserved flag do not affect
  // prediction or resolution.
  logic unused_bits;
  assign unused_bits = ^{flags_i[0], lookup_pc_i[XLEN-1:IDX_W]};

  assign lookup_idx   = lookup_pc_i[IDX_W-1:0];
  assign upd_idx      = pc_i[IDX_W-1:0];
  // No bypass: a same-cycle update to this entry is visible next cycle.
  assign pred_taken_o = bht[lookup_idx][1];

  assign cc_sel = cc_sel_e'(cc_i[2:0]);

  // NOTE: give every combinational output a default before the case so no
  // path leaves it unassigned, which would infer a latch.
  always_comb begin
    raw_cond = 1'b0;
    unique case (cc_sel)
      CC_ALWAYS: raw_cond = 1'b1;
      CC_Z:      raw_cond = flags_i[5];
      CC_P:      raw_cond = flags_i[4];
      CC_N:      raw_cond = flags_i[3];
      CC_C:      raw_cond = flags_i[2];
      CC_V:      raw_cond = flags_i[1];
      CC_NEVER0,
      CC_NEVER1: raw_cond = 1'b0;
    endcase
  end

  assign taken        = raw_cond ^ cc_i[3];
  assign accept       = valid_i & ~flush_i;
  assign mispredict   = taken ^ pred_taken_i;
  // Both sums drop the carry-out, so addresses wrap modulo 2^XLEN.
  assign target       = abs_i ? src_i : pc_i + src_i;
  assign fall_through = pc_i + XLEN'(1);

  // Saturating step of the entry being resolved.
  always_comb begin
    bht_next = bht[upd_idx];
    if (taken) begin
      if (bht[upd_idx] != 2'b11) bht_next = bht[upd_idx] + 2'b01;
    end else begin
      if (bht[upd_idx] != 2'b00) bht_next = bht[upd_idx] - 2'b01;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      valid_o         <= 1'b0;
      mispredict_o    <= 1'b0;
      branch_en_o     <= 1'b0;
      dest_addr_o     <= '0;
      redirect_addr_o <= '0;
    end else begin
      valid_o      <= accept;
      mispredict_o <= accept & mispredict;
      // Payload holds its last value when nothing is accepted.
      if (accept) begin
        branch_en_o     <= taken;
        dest_addr_o     <= target;
        redirect_addr_o <= taken ? target : fall_through;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      mispred_cnt_o <= '0;
    end else if (accept && mispredict && (mispred_cnt_o != '1)) begin
      mispred_cnt_o <= mispred_cnt_o + CNT_W'(1);
    end
  end

  // NOTE: the BHT is a flop array, not RAM, because every entry must be
  // forced to weak-not-taken by the asynchronous reset.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < BHT_DEPTH; i++) bht[i] <= BHT_RESET;
    end else if (accept) begin
      bht[upd_idx] <= bht_next;
    end
  end

endmodule

// File: doc/branch_pred_unit.md
BRANCH_PRED_UNIT -- requirements
Module: branch_pred_unit

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, giving the address/operand width.
REQ-002 The block SHALL have parameter BHT_DEPTH, default 16, giving the number of BHT entries; it SHALL be a power of two, at least 2.
REQ-003 The block SHALL have parameter CNT_W, default 16, giving the width of the mispredict counter.
REQ-004 Port clk_i  in  1  clock; all state SHALL update on its rising edge.
REQ-005 Port rst_n_i  in  1  reset; asynchronous, active-low (one clock; reset asynchronous and active-low).
REQ-006 Port lookup_pc_i  in  XLEN  fetch-stage PC for prediction.
REQ-007 Port pred_taken_o  out  1  combinational prediction; bit 1 of BHT[lookup_pc_i[IDX_W-1:0]], where IDX_W = log2(BHT_DEPTH).
REQ-008 Port valid_i  in  1  resolve request valid.
REQ-009 Port pc_i  in  XLEN  PC of the branch being resolved.
REQ-010 Port cc_i  in  4  condition code; [2:0] select, [3] invert.
REQ-011 Port flags_i  in  6  flags; [5] Z, [4] P, [3] N, [2] C, [1] V, [0] reserved.
REQ-012 Port src_i  in  XLEN  branch offset, or absolute target.
REQ-013 Port abs_i  in  1  1 = absolute target, 0 = PC-relative target.
REQ-014 Port pred_taken_i  in  1  prediction that fetch used for this branch.
REQ-015 Port flush_i  in  1  cancels the request in the same cycle.
REQ-016 Port valid_o  out  1  registered result valid.
REQ-017 Port branch_en_o  out  1  registered actual-taken.
REQ-018 Port dest_addr_o  out  XLEN  registered branch target.
REQ-019 Port mispredict_o  out  1  registered; prediction differed from outcome.
REQ-020 Port redirect_addr_o  out  XLEN  registered correct next PC.
REQ-021 Port mispred_cnt_o  out  CNT_W  saturating mispredict count.

Function
REQ-022 The raw condition SHALL be decoded from cc_i[2:0] as: 000 always, 001 Z, 010 P, 011 N, 100 C, 101 V, 110/111 never.
REQ-023 The taken result SHALL equal the raw condition XOR cc_i[3]; so 1000 is never-taken and 1110/1111 are always-taken.
REQ-024 The target SHALL be src_i when abs_i=1, else (pc_i + src_i) mod 2^XLEN, with no carry-out.
REQ-025 The fall-through address SHALL be (pc_i + 1) mod 2^XLEN; all-ones wraps to 0.
REQ-026 Latency SHALL be one cycle: an accepted request (valid_i=1, flush_i=0) at edge N SHALL produce outputs valid for the cycle after edge N.
REQ-027 valid_o SHALL be 1 for exactly one cycle per accepted request; back-to-back requests SHALL give back-to-back results.
REQ-028 When valid_i=0 or flush_i=1 at an edge, valid_o and mispredict_o SHALL be 0 next cycle.
REQ-029 In that case, dest_addr_o, redirect_addr_o and branch_en_o SHALL hold their previous values.
REQ-030 mispredict_o SHALL be 1 if and only if taken != pred_taken_i.
REQ-031 redirect_addr_o SHALL be the target when taken, else the fall-through address.
REQ-032 Each BHT entry SHALL be a 2-bit saturating counter: 00 strong-not-taken, 01 weak-not-taken, 10 weak-taken, 11 strong-taken.
REQ-033 On an accepted request, entry pc_i[IDX_W-1:0] SHALL increment if taken and decrement if not, at the same edge that registers the result.
REQ-034 A taken update at 11 SHALL leave the entry at 11; a not-taken update at 00 SHALL leave it at 00.
REQ-035 A flushed request SHALL NOT update the BHT or the mispredict counter.
REQ-036 When lookup and update hit the same index in one cycle, pred_taken_o SHALL reflect the pre-update value; there is no bypass.
REQ-037 mispred_cnt_o SHALL increment at each edge that registers mispredict=1, saturating at all-ones.

Reset
REQ-038 While rst_n_i=0, the block SHALL immediately force valid_o=0, branch_en_o=0, mispredict_o=0, dest_addr_o=0, redirect_addr_o=0 and mispred_cnt_o=0, independent of clk_i.
REQ-039 While rst_n_i=0, every BHT entry SHALL be forced to 01, so pred_taken_o=0 for any lookup.
REQ-040 Reset asserted mid-operation SHALL discard any in-flight result.
REQ-041 The first request accepted after rst_n_i deassertion SHALL behave as if it were the first request after power-up.

Verification
REQ-042 The bench SHALL cover: pc=0x10, src=0xFFFFFFF0, abs=0, cc=0000, pred=0 -> next cycle valid_o=1, dest=0x0, branch_en=1, mispredict=1, redirect=0x0, cnt=1.
REQ-043 The bench SHALL cover: cc=0001 with flags=000000, then cc=1001 with flags=000000, back-to-back -> branch_en 0 then 1 on consecutive cycles; cc=0110 -> 0; cc=1110 -> 1.
REQ-044 The bench SHALL cover: four taken resolves at pc=0x3 -> entry 3 goes 01->10->11->11->11; lookup_pc=0x13 with BHT_DEPTH=16 -> pred_taken_o=1 after the first update.
REQ-045 The bench SHALL cover: pc=0xFFFFFFFF, cc=0110 (never), pred=1 -> redirect=0x0, mispredict=1.
REQ-046 The bench SHALL cover: a request with flush_i=1 -> valid_o=0, with BHT and counter unchanged; with CNT_W=2, five mispredicts -> cnt=3.
REQ-047 The bench SHALL cover: rst_n_i pulsed low between clock edges with valid_o=1 -> outputs 0 immediately, and pred_taken_o=0 for all indices.
